// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding RV32I load/store responder with wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
   parameter int WAIT_STATES = 1,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [11:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;

   logic            r_write;
   logic [11:0]     r_addr;
   logic [2:0]      r_funct3;
   logic [31:0]     r_wdata;
   logic            r_err;
   logic [31:0]     r_rd_word;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic            w_accept;
   logic            w_enter_resp;
   logic            w_mem_we;
   logic            w_op_write;
   logic [11:0]     w_op_addr;
   logic [2:0]      w_op_funct3;
   logic [31:0]     w_op_wdata;
   logic [c_AW-1:0] w_idx;
   logic            w_err;
   logic [3:0]      w_be;
   logic [31:0]     w_wlane;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_load_val;

   assign w_accept     = req_valid && (r_state == c_IDLE);
   assign w_enter_resp = (w_state_nxt == c_RESP) && (r_state != c_RESP);

   // With zero wait states the access happens on the accepting edge, so the
   // operation fields come straight from the request port in that case.
   assign w_op_write  = (r_state == c_IDLE) ? req_write  : r_write;
   assign w_op_addr   = (r_state == c_IDLE) ? req_addr   : r_addr;
   assign w_op_funct3 = (r_state == c_IDLE) ? req_funct3 : r_funct3;
   assign w_op_wdata  = (r_state == c_IDLE) ? req_wdata  : r_wdata;
   assign w_idx       = w_op_addr[c_AW+1:2];
   assign w_mem_we    = Reset && w_enter_resp && w_op_write && !w_err;

   // State register
   always_ff @(posedge clk) begin
      if (!Reset) begin
         r_state <= c_IDLE;
         r_cnt   <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_enter_resp) begin
            r_err <= w_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_write  <= req_write;
         r_addr   <= req_addr;
         r_funct3 <= req_funct3;
         r_wdata  <= req_wdata;
      end
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (w_enter_resp) begin
         r_rd_word <= r_mem[w_idx];
      end
      for (int i = 0; i < 4; i++) begin
         if (w_mem_we && w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_IDLE: begin
            if (req_valid) begin
               w_cnt_nxt = c_WAIT_INIT;
               if (WAIT_STATES == 0) begin
                  w_state_nxt = c_RESP;
               end else begin
                  w_state_nxt = c_WAIT;
               end
            end
         end
         c_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = c_RESP;
            end
         end
         c_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_err = 1'b0;
      case (w_op_funct3)
         3'b000:  w_err = 1'b0;
         3'b001:  w_err = w_op_addr[0];
         3'b010:  w_err = (w_op_addr[1:0] != 2'b00);
         3'b100:  w_err = w_op_write;
         3'b101:  w_err = w_op_write || w_op_addr[0];
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_be    = 4'b0000;
      w_wlane = w_op_wdata;
      case (w_op_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_op_addr[1:0];
            w_wlane = {4{w_op_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_op_wdata[15:0]}};
         end
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   assign w_byte = r_rd_word[8*r_addr[1:0] +: 8];
   assign w_half = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

   always_comb begin
      w_load_val = 32'd0;
      case (r_funct3)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b010:  w_load_val = r_rd_word;
         3'b100:  w_load_val = {24'd0, w_byte};
         3'b101:  w_load_val = {16'd0, w_half};
         default: w_load_val = 32'd0;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = (r_state == c_IDLE);
      rsp_valid = (r_state == c_RESP);
      rsp_err   = rsp_valid && r_err;
      rsp_rdata = (rsp_valid && !r_err && !r_write) ? w_load_val : 32'd0;
   end

endmodule

`default_nettype wire
